// File: rtl/mpq_cmd_scheduler.sv
// Round-robin scheduler sharing one MPQ command port among NREQ requesters.
// Optional watchdog enabled by defining MPQ_SCHED_WDOG_EN.
module mpq_cmd_scheduler #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NREQ-1:0]              req_i,
    input  logic [3*NREQ-1:0]            req_cmd_i,
    input  logic [8*NREQ-1:0]            req_index_i,
    input  logic [DATA_WIDTH*NREQ-1:0]   req_value_i,
    output logic [NREQ-1:0]              gnt_o,
    output logic [NREQ-1:0]              ack_o,
    output logic                         err_o,
    output logic                         sched_busy_o,
    input  logic                         mpq_busy_i,
    input  logic                         mpq_done_i,
    output logic                         mpq_cmd_valid_o,
    output logic [2:0]                   mpq_cmd_o,
    output logic [7:0]                   mpq_index_o,
    output logic [DATA_WIDTH-1:0]        mpq_value_o
);

    localparam int unsigned PtrW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 2) begin : g_bad_params
        $error("mpq_cmd_scheduler: NREQ must be 2..8 and WDOG_CYCLES at least 2");
    end

    typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitDone, StAck} state_e;

    state_e                  state_q;
    logic [PtrW-1:0]         rr_ptr_q;
    logic [PtrW-1:0]         id_q;
    logic [2:0]              cmd_q;
    logic [NREQ-1:0]         gnt_q;
    logic [NREQ-1:0]         ack_q;
    logic                    err_q;
    logic                    sched_busy_q;
    logic                    cmd_valid_q;
    logic [2:0]              mpq_cmd_q;
    logic [7:0]              mpq_index_q;
    logic [DATA_WIDTH-1:0]   mpq_value_q;

    logic                    win_found;
    logic [PtrW-1:0]         win_id;
    logic [2:0]              win_cmd;
    logic [7:0]              win_index;
    logic [DATA_WIDTH-1:0]   win_value;
    logic [PtrW-1:0]         rr_ptr_next;
    logic                    wdog_hit;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic [PtrW-1:0] idx_w;
        win_found = 1'b0;
        win_id    = rr_ptr_q;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = PtrW'(idx);
            if (!win_found && req_i[idx_w]) begin
                win_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    assign win_cmd     = req_cmd_i[3*win_id +: 3];
    assign win_index   = req_index_i[8*win_id +: 8];
    assign win_value   = req_value_i[DATA_WIDTH*win_id +: DATA_WIDTH];
    assign rr_ptr_next = (id_q == PtrW'(NREQ - 1)) ? '0 : id_q + 1'b1;

`ifdef MPQ_SCHED_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

    logic [WdogW-1:0] wdog_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_cnt_q <= '0;
        end else if (state_q == StIssue) begin
            wdog_cnt_q <= '0;
        end else if (state_q == StWaitStart || state_q == StWaitDone) begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
        end
    end

    // Fires on the edge where the count reaches WDOG_CYCLES-1.
    assign wdog_hit = (state_q == StWaitStart || state_q == StWaitDone) &&
                      (wdog_cnt_q == WdogW'(WDOG_CYCLES - 2));
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            cmd_q        <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            sched_busy_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            mpq_cmd_q    <= '0;
            mpq_index_q  <= '0;
            mpq_value_q  <= '0;
        end else begin
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_found && !mpq_busy_i) begin
                        id_q         <= win_id;
                        cmd_q        <= win_cmd;
                        sched_busy_q <= 1'b1;
                        if (win_cmd > 3'd4) begin
                            // Illegal command never reaches the MPQ.
                            state_q <= StAck;
                            ack_q   <= NREQ'(1) << win_id;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= StIssue;
                            gnt_q       <= NREQ'(1) << win_id;
                            cmd_valid_q <= 1'b1;
                            mpq_cmd_q   <= win_cmd;
                            mpq_index_q <= win_index;
                            mpq_value_q <= win_value;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWaitStart;
                end
                StWaitStart: begin
                    if (mpq_busy_i) begin
                        state_q <= StWaitDone;
                    end else if (cmd_q == 3'd4 && mpq_done_i) begin
                        state_q <= StAck;
                        ack_q   <= NREQ'(1) << id_q;
                    end else if (wdog_hit) begin
                        state_q <= StAck;
                        ack_q   <= NREQ'(1) << id_q;
                        err_q   <= 1'b1;
                    end
                end
                StWaitDone: begin
                    if ((cmd_q == 3'd4) ? mpq_done_i : !mpq_busy_i) begin
                        state_q <= StAck;
                        ack_q   <= NREQ'(1) << id_q;
                    end else if (wdog_hit) begin
                        state_q <= StAck;
                        ack_q   <= NREQ'(1) << id_q;
                        err_q   <= 1'b1;
                    end
                end
                StAck: begin
                    state_q      <= StIdle;
                    sched_busy_q <= 1'b0;
                    rr_ptr_q     <= rr_ptr_next;
                end
                default: begin
                    state_q      <= StIdle;
                    sched_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o           = gnt_q;
    assign ack_o           = ack_q;
    assign err_o           = err_q;
    assign sched_busy_o    = sched_busy_q;
    assign mpq_cmd_valid_o = cmd_valid_q;
    assign mpq_cmd_o       = mpq_cmd_q;
    assign mpq_index_o     = mpq_index_q;
    assign mpq_value_o     = mpq_value_q;

endmodule

// File: tb/tb_mpq_cmd_scheduler.sv
// Directed self-checking bench for mpq_cmd_scheduler (NREQ=4, DATA_WIDTH=8, WDOG_CYCLES=16).
module tb_mpq_cmd_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
`ifdef MPQ_SCHED_WDOG_EN
    localparam int DoneDelay = 12;
`else
    localparam int DoneDelay = 20;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_cmd;
    logic [8*NREQ-1:0] req_index;
    logic [DW*NREQ-1:0] req_value;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              sched_busy;
    logic              mpq_busy;
    logic              mpq_done;
    logic              mpq_cmd_valid;
    logic [2:0]        mpq_cmd;
    logic [7:0]        mpq_index;
    logic [DW-1:0]     mpq_value;

    int checks = 0;
    int errors = 0;

    mpq_cmd_scheduler #(
        .NREQ        (NREQ),
        .DATA_WIDTH  (DW),
        .WDOG_CYCLES (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .req_cmd_i       (req_cmd),
        .req_index_i     (req_index),
        .req_value_i     (req_value),
        .gnt_o           (gnt),
        .ack_o           (ack),
        .err_o           (err),
        .sched_busy_o    (sched_busy),
        .mpq_busy_i      (mpq_busy),
        .mpq_done_i      (mpq_done),
        .mpq_cmd_valid_o (mpq_cmd_valid),
        .mpq_cmd_o       (mpq_cmd),
        .mpq_index_o     (mpq_index),
        .mpq_value_o     (mpq_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] c, input logic [7:0] ix,
                           input logic [7:0] v);
        req_cmd[3*id +: 3]    = c;
        req_index[8*id +: 8]  = ix;
        req_value[DW*id +: DW] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_sbusy"}, 32'(sched_busy), 0);
        chk({tag, "_valid"}, 32'(mpq_cmd_valid), 0);
        chk({tag, "_cmd"}, 32'(mpq_cmd), 0);
        chk({tag, "_index"}, 32'(mpq_index), 0);
        chk({tag, "_value"}, 32'(mpq_value), 0);
    endtask

    // Bounded wait for a grant, then compare it.
    task automatic wait_gnt(input int id, input logic [2:0] c);
        for (int i = 0; i < 40 && gnt === '0; i++) @(negedge clk);
        chk("gnt", 32'(gnt), 32'(1) << id);
        chk("cmd_valid", 32'(mpq_cmd_valid), 1);
        chk("mpq_cmd", 32'(mpq_cmd), 32'(c));
        chk("sched_busy", 32'(sched_busy), 1);
    endtask

    // Grant, MPQ busy for busy_cycles, ack one cycle after busy drops.
    task automatic run_cmd(input int id, input logic [2:0] c, input int busy_cycles,
                           input bit reraise);
        wait_gnt(id, c);
        req[id]  = 1'b0;
        mpq_busy = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            chk("ack_early", 32'(ack), 0);
            chk("valid_pulse", 32'(mpq_cmd_valid), 0);
        end
        mpq_busy = 1'b0;
        @(negedge clk);
        chk("ack", 32'(ack), 32'(1) << id);
        chk("err", 32'(err), 0);
        if (reraise) req[id] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; req_cmd = '0; req_index = '0; req_value = '0;
        mpq_busy = 1'b0; mpq_done = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // 1: MPQ load phase blocks issue.
        mpq_busy = 1'b1;
        set_req(0, 3'd3, 8'h11, 8'h5A);
        req = 4'b0001;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("blocked_gnt", 32'(gnt), 0);
            chk("blocked_sbusy", 32'(sched_busy), 0);
        end
        mpq_busy = 1'b0;
        run_cmd(0, 3'd3, 3, 1'b0);
        chk("t1_value", 32'(mpq_value), 32'h5A);
        chk("t1_index", 32'(mpq_index), 32'h11);

        // 2: all four requesting, round-robin 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) set_req(k, 3'(k), 8'(8'h20 + k), 8'(8'h30 + k));
        req = 4'b1111;
        run_cmd(0, 3'd0, 3, 1'b1);
        run_cmd(1, 3'd1, 3, 1'b1);
        run_cmd(2, 3'd2, 3, 1'b1);
        run_cmd(3, 3'd3, 3, 1'b1);
        run_cmd(0, 3'd0, 3, 1'b0);
        req = '0;
        chk("t2_value", 32'(mpq_value), 32'h30);

        // 3: write-RAM completes on done, busy ignored.
        set_req(2, 3'd4, 8'h44, 8'h99);
        req = 4'b0100;
        wait_gnt(2, 3'd4);
        req = '0;
        mpq_busy = 1'b1;
        repeat (DoneDelay) begin
            @(negedge clk);
            chk("t3_ack_early", 32'(ack), 0);
        end
        mpq_done = 1'b1;
        @(negedge clk);
        chk("t3_ack", 32'(ack), 32'b0100);
        chk("t3_err", 32'(err), 0);
        mpq_done = 1'b0;
        @(negedge clk);
        chk("t3_idle", 32'(sched_busy), 0);
        mpq_busy = 1'b0;

        // 4: illegal command acked with err, MPQ untouched.
        set_req(1, 3'd6, 8'h77, 8'h88);
        req = 4'b0010;
        @(negedge clk);
        chk("t4_ack", 32'(ack), 32'b0010);
        chk("t4_err", 32'(err), 1);
        chk("t4_valid", 32'(mpq_cmd_valid), 0);
        chk("t4_gnt", 32'(gnt), 0);
        chk("t4_cmd_held", 32'(mpq_cmd), 4);
        req = '0;
        @(negedge clk);
        chk("t4_err_pulse", 32'(err), 0);
        chk("t4_valid2", 32'(mpq_cmd_valid), 0);

        // 5: reset in WAIT_DONE abandons the command and restarts from requester 0.
        set_req(3, 3'd1, 8'h12, 8'h34);
        req = 4'b1000;
        wait_gnt(3, 3'd1);
        req = '0;
        mpq_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_sbusy", 32'(sched_busy), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        mpq_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_no_ack", 32'(ack), 0);
        set_req(1, 3'd2, 8'h55, 8'h66);
        set_req(3, 3'd2, 8'h57, 8'h67);
        req = 4'b1010;
        run_cmd(1, 3'd2, 3, 1'b0);
        req = '0;
        chk("t5_value", 32'(mpq_value), 32'h66);

`ifdef MPQ_SCHED_WDOG_EN
        // 6: watchdog fires with busy stuck high, then grants stay blocked.
        set_req(0, 3'd2, 8'h0A, 8'h0B);
        req = 4'b0001;
        wait_gnt(0, 3'd2);
        req = '0;
        mpq_busy = 1'b1;
        repeat (15) begin
            @(negedge clk);
            chk("t6_ack_early", 32'(ack), 0);
        end
        @(negedge clk);
        chk("t6_ack", 32'(ack), 32'b0001);
        chk("t6_err", 32'(err), 1);
        req = 4'b0001;
        repeat (10) begin
            @(negedge clk);
            chk("t6_blocked", 32'(gnt), 0);
        end
        mpq_busy = 1'b0;
        wait_gnt(0, 3'd2);
        req = '0;
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
